squeeze_stage: RTL
==================

// Module: squeeze_stage
// PURPOSE
//  Final SHAKE pipeline stage, directly downstream of the permute stage.
//  Accepts one permuted rate block per handshake and streams it out as W-bit words.
//  Truncates to the requested output length and zero-masks the final partial word.
//  Flags the last word of the whole digest.
// PARAMETERS
//  W       64    output word width (= Keccak lane width w)
//  RATE_W  1344  block input width (= RATE_SHAKE128, widest rate)
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, asynchronous, active-low
//  block_in     in   RATE_W  rate block, already endian-switched; word0 = block_in[RATE_W-1 -: W]
//  mode_in      in   2       operation mode (SHAKE128_MODE_VEC / SHAKE256_MODE_VEC)
//  size_in      in   32      output bits still owed, including this block
//  last_in      in   1       this block is the final output block
//  block_valid  in   1       block_in / mode_in / size_in / last_in valid
//  block_ready  out  1       stage can accept a block
//  data_out     out  W       output word
//  data_bits    out  7       valid bits in data_out, 1..64, MSB-aligned
//  data_last    out  1       final word of the digest
//  data_valid   out  1       data_out valid
//  data_ready   in   1       consumer accepts data_out
//  mode_err     out  1       sticky: a block arrived with an unsupported mode
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; word counter=0; block register=0; mode_err=0.
//   Outputs: data_valid=0, data_out=0, data_bits=0, data_last=0, block_ready=1.
//  Handshakes: a transfer occurs on a clock edge where valid&&ready.
//   Producer holds its fields stable while valid=1 and ready=0.
//  Words per block: blk_words = 21 (SHAKE128), 17 (SHAKE256), 0 (other mode).
//   n = min(blk_words, ceil(size_in/W)), computed in 32-bit unsigned arithmetic.
//  FSM IDLE: block_ready=1, data_valid=0.
//   On block handshake: latch block, n, last_in, and size_in[5:0].
//   If n==0: block is dropped and state stays IDLE. An unsupported mode also sets mode_err.
//   Otherwise go to DRAIN.
//  FSM DRAIN: data_valid=1, data_out = block_reg[RATE_W-1 -: W].
//   On each word handshake: shift block_reg left by W (zero fill); decrement the counter.
//   After the handshake of word n: go to IDLE (see CONFIGURATION for the alternative).
//  Final word of a block, when size_in[5:0]!=0 and ceil(size_in/W) <= blk_words:
//   data_bits = size_in[5:0]; bits below the valid bits are forced to 0.
//   In every other case data_bits=64.
//  data_last=1 only on word n of a block latched with last_in=1.
//  Latency: block handshake -> data_valid one cycle later. One word per cycle while data_ready=1.
//  data_ready low: data_out, data_bits and data_last hold unchanged.
//  Reset mid-drain: state, counters and the buffer clear at once; in-flight words are lost.
//  mode_err clears only on reset.
// CONFIGURATION
//  SQUEEZE_DOUBLE_BUFFER_EN defined:
//   Adds a second block register (shadow).
//   In DRAIN, block_ready=1 while the shadow is empty, so the permute stage can deliver early.
//   After the last word's handshake, if the shadow is full, it moves to the active register that
//   same edge: next word 0 appears the following cycle with no bubble, and the shadow is freed.
//   A block latched with n==0 into the shadow is dropped there.
//  Not defined: single register; block_ready = (state==IDLE).
// TESTING
//  SHAKE128, size_in=256, last=1, data_ready=1 -> 4 words;
//   data_bits=64 on all; data_last only on word 3; back to IDLE.
//  SHAKE256, size_in=2000, last=0 -> 17 words, data_last=0, block_ready=1 after word 16;
//   then size_in=912, last=1 -> 15 words; word 14 has data_bits=16, low 48 bits zero, data_last=1.
//  data_ready toggled 1010... during drain -> each word held stable while ready=0;
//   no word lost or duplicated versus the reference model.
//  mode_in=2'b11 or size_in=0 -> block accepted, no data_valid;
//   mode_err=1 only for the bad-mode case, persists until rst.
//  rst pulsed low mid-drain (after word 5 of 21) -> data_valid=0 immediately;
//   next block drains from its word 0.
//  DOUBLE_BUFFER_EN: two SHAKE128 blocks back-to-back, data_ready=1
//   -> 42 consecutive data_valid cycles, no bubble between blocks.

Source files
------------

// File: rtl/squeeze_stage.sv
// squeeze_stage: streams permuted SHAKE rate blocks out as W-bit words, truncated and masked to the requested length.
// SQUEEZE_DOUBLE_BUFFER_EN adds a shadow block register so the next block can be accepted while draining.
module squeeze_stage #(
    parameter int         W                 = 64,
    parameter int         RATE_W            = 1344,
    parameter logic [1:0] SHAKE128_MODE_VEC = 2'b00,
    parameter logic [1:0] SHAKE256_MODE_VEC = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RATE_W-1:0] block_in,
    input  logic [1:0]        mode_in,
    input  logic [31:0]       size_in,
    input  logic              last_in,
    input  logic              block_valid,
    output logic              block_ready,
    output logic [W-1:0]      data_out,
    output logic [6:0]        data_bits,
    output logic              data_last,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              mode_err
);
    localparam int LW = $clog2(W);
    localparam int CW = $clog2(RATE_W / W + 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t            state;
    logic [RATE_W-1:0] blk_reg;
    logic [CW-1:0]     cnt;
    logic              last_r, part_r;
    logic [LW-1:0]     sz_r;
    logic [31:0]       blk_words, ceil_w, n_calc;
    logic              part_in, blk_hs, word_hs, word_done, fin;
    logic [W-1:0]      mask;
`ifdef SQUEEZE_DOUBLE_BUFFER_EN
    logic [RATE_W-1:0] sh_blk;
    logic [CW-1:0]     sh_cnt;
    logic              sh_last, sh_part, sh_full;
    logic [LW-1:0]     sh_sz;
`endif

    always_comb begin
        blk_words = mode_in == SHAKE128_MODE_VEC ? 32'(RATE_W / W) :
                    mode_in == SHAKE256_MODE_VEC ? 32'(1088 / W) : 32'd0;
        ceil_w    = (size_in + 32'(W - 1)) / 32'(W);
        n_calc    = ceil_w < blk_words ? ceil_w : blk_words;
        // Only the block that actually reaches the end of the digest has a partial final word.
        part_in   = (|size_in[LW-1:0]) && ceil_w <= blk_words;
`ifdef SQUEEZE_DOUBLE_BUFFER_EN
        block_ready = state == IDLE || !sh_full;
`else
        block_ready = state == IDLE;
`endif
        blk_hs     = block_valid && block_ready;
        data_valid = state == DRAIN;
        word_hs    = data_valid && data_ready;
        word_done  = word_hs && cnt == CW'(1);
        fin        = data_valid && cnt == CW'(1) && part_r;
        mask       = fin ? ~({W{1'b1}} >> sz_r) : {W{1'b1}};
        data_out   = data_valid ? blk_reg[RATE_W-1 -: W] & mask : '0;
        data_bits  = !data_valid ? 7'd0 : fin ? 7'(sz_r) : 7'(W);
        data_last  = data_valid && cnt == CW'(1) && last_r;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            blk_reg  <= '0;
            cnt      <= '0;
            last_r   <= 1'b0;
            part_r   <= 1'b0;
            sz_r     <= '0;
            mode_err <= 1'b0;
`ifdef SQUEEZE_DOUBLE_BUFFER_EN
            sh_blk   <= '0;
            sh_cnt   <= '0;
            sh_last  <= 1'b0;
            sh_part  <= 1'b0;
            sh_sz    <= '0;
            sh_full  <= 1'b0;
`endif
        end else begin
            if (blk_hs && blk_words == 32'd0) mode_err <= 1'b1;
            if (word_hs) begin
                blk_reg <= blk_reg << W;
                cnt     <= cnt - 1'b1;
            end
            if (word_done) state <= IDLE;
`ifdef SQUEEZE_DOUBLE_BUFFER_EN
            if (word_done && sh_full) begin
                state   <= DRAIN;
                blk_reg <= sh_blk;
                cnt     <= sh_cnt;
                last_r  <= sh_last;
                part_r  <= sh_part;
                sz_r    <= sh_sz;
                sh_full <= 1'b0;
            end
            // A block arriving on the final word's edge goes straight to the active register.
            if (blk_hs && n_calc != 32'd0 && state == DRAIN && !word_done) begin
                sh_blk  <= block_in;
                sh_cnt  <= CW'(n_calc);
                sh_last <= last_in;
                sh_part <= part_in;
                sh_sz   <= size_in[LW-1:0];
                sh_full <= 1'b1;
            end else if (blk_hs && n_calc != 32'd0) begin
`else
            if (blk_hs && n_calc != 32'd0) begin
`endif
                state   <= DRAIN;
                blk_reg <= block_in;
                cnt     <= CW'(n_calc);
                last_r  <= last_in;
                part_r  <= part_in;
                sz_r    <= size_in[LW-1:0];
            end
        end
    end
endmodule
